// File: rtl/sobel_window_scheduler_pkg.sv
// Shared types and constants for the Sobel window scheduler.
package sobel_window_scheduler_pkg;

  localparam int unsigned DEFAULT_IMG_WIDTH   = 16;
  localparam int unsigned DEFAULT_IMG_HEIGHT  = 16;
  localparam int unsigned DEFAULT_PIXEL_WIDTH = 8;

  // Pixels sobel_control samples for its first window and for each column update.
  localparam int unsigned SOBEL_FIRST_PIX = 9;
  localparam int unsigned SOBEL_COL_PIX   = 3;

  // Rows held in the strip buffer.
  localparam int unsigned RING_ROWS = 3;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StLead,
    StPix1st,
    StGap,
    StPixCol,
    StStripEnd,
    StDone
  } sched_state_t;

  // Logical row (0 = oldest) to physical ring row, given the ring pointer.
  function automatic logic [1:0] ring_row(input logic [1:0] ptr, input logic [1:0] lrow);
    logic [2:0] sum;
    sum = {1'b0, ptr} + {1'b0, lrow};
    if (sum >= 3'd3) begin
      sum = sum - 3'd3;
    end
    return sum[1:0];
  endfunction

endpackage

// File: rtl/sobel_window_scheduler_if.sv
// Raster input / sobel_control output bundle of the window scheduler.
interface sobel_window_scheduler_if
  import sobel_window_scheduler_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH
);

  logic                   frame_start_i;
  logic                   px_valid_i;
  logic [PIXEL_WIDTH-1:0] px_gray_i;
  logic                   in_ready_o;
  logic                   start_o;
  logic [PIXEL_WIDTH-1:0] gray_o;
  logic                   busy_o;
  logic                   frame_done_o;

  // Scheduler side.
  modport slave (
    input  frame_start_i,
    input  px_valid_i,
    input  px_gray_i,
    output in_ready_o,
    output start_o,
    output gray_o,
    output busy_o,
    output frame_done_o
  );

  // Raster source / observer side.
  modport master (
    output frame_start_i,
    output px_valid_i,
    output px_gray_i,
    input  in_ready_o,
    input  start_o,
    input  gray_o,
    input  busy_o,
    input  frame_done_o
  );

endinterface

// File: rtl/sobel_window_scheduler_line_buffer.sv
// Three-row strip store: one write port and one registered read port, both addressed by
// logical row through the ring pointer so the caller never deals with physical rows.
module sobel_window_scheduler_line_buffer
  import sobel_window_scheduler_pkg::*;
#(
  parameter int unsigned IMG_WIDTH   = DEFAULT_IMG_WIDTH,
  parameter int unsigned PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH,
  localparam int unsigned ColW       = $clog2(IMG_WIDTH)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [1:0]             ptr_i,
  input  logic                   wr_en_i,
  input  logic [1:0]             wr_lrow_i,
  input  logic [ColW-1:0]        wr_col_i,
  input  logic [PIXEL_WIDTH-1:0] wr_data_i,
  input  logic                   rd_en_i,
  input  logic [1:0]             rd_lrow_i,
  input  logic [ColW-1:0]        rd_col_i,
  output logic [PIXEL_WIDTH-1:0] rd_data_o
);

  logic [PIXEL_WIDTH-1:0] mem_q [RING_ROWS][IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] rd_data_q;
  logic [1:0]             wr_phys;
  logic [1:0]             rd_phys;

  assign wr_phys = ring_row(ptr_i, wr_lrow_i);
  assign rd_phys = ring_row(ptr_i, rd_lrow_i);

  // Pixel storage; contents are don't-care until filled, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_phys][wr_col_i] <= wr_data_i;
    end
  end

  // Registered read; idle slots output zero so the gap/lead cycles need no extra mux.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_phys][rd_col_i];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sobel_window_scheduler.sv
// Buffers a 3-row strip of the raster and replays it column by column in the cadence
// sobel_control samples: lead slot, 9-pixel first window, then gap + 3-pixel column updates.
// The strip slides one row per pass until the frame is exhausted.
module sobel_window_scheduler
  import sobel_window_scheduler_pkg::*;
#(
  parameter int unsigned IMG_WIDTH   = DEFAULT_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT  = DEFAULT_IMG_HEIGHT,
  parameter int unsigned PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  sobel_window_scheduler_if.slave  bus
);

  localparam int unsigned ColW  = $clog2(IMG_WIDTH);
  localparam int unsigned RowsW = $clog2(IMG_HEIGHT + 1);

  localparam logic [ColW-1:0]  LastCol   = ColW'(IMG_WIDTH - 1);
  localparam logic [RowsW-1:0] LastRow   = RowsW'(IMG_HEIGHT);
  localparam logic [3:0]       SlotLast  = 4'(SOBEL_FIRST_PIX - 1);
  localparam logic [1:0]       LrowLast  = 2'(SOBEL_COL_PIX - 1);
  localparam logic [1:0]       TopLrow   = 2'(RING_ROWS - 1);

  sched_state_t     state_q, state_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [1:0]       lrow_q, lrow_d;
  logic [3:0]       slot_q, slot_d;
  logic [ColW-1:0]  wr_col_q, wr_col_d;
  logic [1:0]       wr_lrow_q, wr_lrow_d;
  logic [RowsW-1:0] rows_in_q, rows_in_d;
  logic [1:0]       ptr_q, ptr_d;

  logic in_ready_q, in_ready_d;
  logic start_q, start_d;
  logic busy_q, busy_d;
  logic frame_done_q, frame_done_d;

  logic                   xfer;
  logic                   wr_en;
  logic                   rd_en;
  logic [PIXEL_WIDTH-1:0] gray;

  assign xfer = bus.px_valid_i & in_ready_q;

  // Next-state, counters and registered-output decode.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    lrow_d    = lrow_q;
    slot_d    = slot_q;
    wr_col_d  = wr_col_q;
    wr_lrow_d = wr_lrow_q;
    rows_in_d = rows_in_q;
    ptr_d     = ptr_q;
    wr_en     = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.frame_start_i) begin
          state_d   = StFill;
          wr_lrow_d = 2'd0;
          wr_col_d  = '0;
          rows_in_d = '0;
          ptr_d     = 2'd0;
        end
      end
      StFill: begin
        // First fill walks logical rows 0..2; refills start at row 2, so both end there.
        if (xfer) begin
          wr_en = 1'b1;
          if (wr_col_q == LastCol) begin
            wr_col_d  = '0;
            rows_in_d = rows_in_q + RowsW'(1);
            if (wr_lrow_q == TopLrow) begin
              state_d = StLead;
            end else begin
              wr_lrow_d = wr_lrow_q + 2'd1;
            end
          end else begin
            wr_col_d = wr_col_q + ColW'(1);
          end
        end
      end
      StLead: begin
        state_d = StPix1st;
        col_d   = '0;
        lrow_d  = 2'd0;
        slot_d  = 4'd0;
      end
      StPix1st: begin
        if (slot_q == SlotLast) begin
          slot_d  = 4'd0;
          state_d = (IMG_WIDTH > 3) ? StGap : StStripEnd;
        end else begin
          slot_d = slot_q + 4'd1;
          if (lrow_q == LrowLast) begin
            lrow_d = 2'd0;
            col_d  = col_q + ColW'(1);
          end else begin
            lrow_d = lrow_q + 2'd1;
          end
        end
      end
      StGap: begin
        state_d = StPixCol;
        col_d   = col_q + ColW'(1);
        lrow_d  = 2'd0;
      end
      StPixCol: begin
        if (lrow_q == LrowLast) begin
          if (col_q == LastCol) begin
            state_d = StStripEnd;
            slot_d  = 4'd0;
          end else begin
            state_d = StGap;
          end
        end else begin
          lrow_d = lrow_q + 2'd1;
        end
      end
      StStripEnd: begin
        // Two idle cycles; the second lets a W=3 sobel_control clear NEXT_MATRIX.
        if (slot_q == 4'd0) begin
          slot_d = 4'd1;
        end else if (rows_in_q == LastRow) begin
          state_d = StDone;
          slot_d  = 4'd0;
        end else begin
          state_d   = StFill;
          slot_d    = 4'd0;
          ptr_d     = ring_row(ptr_q, 2'd1);
          wr_lrow_d = TopLrow;
          wr_col_d  = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered from the next state so they change on the same edge as the state.
    rd_en        = (state_d == StPix1st) || (state_d == StPixCol);
    in_ready_d   = (state_d == StFill);
    start_d      = (state_d == StLead) || (state_d == StPix1st) ||
                   (state_d == StGap)  || (state_d == StPixCol);
    busy_d       = (state_d != StIdle) && (state_d != StDone);
    frame_done_d = (state_d == StDone);
  end

  // State, counters and output registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      col_q        <= '0;
      lrow_q       <= 2'd0;
      slot_q       <= 4'd0;
      wr_col_q     <= '0;
      wr_lrow_q    <= 2'd0;
      rows_in_q    <= '0;
      ptr_q        <= 2'd0;
      in_ready_q   <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      lrow_q       <= lrow_d;
      slot_q       <= slot_d;
      wr_col_q     <= wr_col_d;
      wr_lrow_q    <= wr_lrow_d;
      rows_in_q    <= rows_in_d;
      ptr_q        <= ptr_d;
      in_ready_q   <= in_ready_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Read address uses next-cycle row/column so data lands together with the state.
  sobel_window_scheduler_line_buffer #(
    .IMG_WIDTH   (IMG_WIDTH),
    .PIXEL_WIDTH (PIXEL_WIDTH)
  ) u_line_buffer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .ptr_i     (ptr_q),
    .wr_en_i   (wr_en),
    .wr_lrow_i (wr_lrow_q),
    .wr_col_i  (wr_col_q),
    .wr_data_i (bus.px_gray_i),
    .rd_en_i   (rd_en),
    .rd_lrow_i (lrow_d),
    .rd_col_i  (col_d),
    .rd_data_o (gray)
  );

  assign bus.in_ready_o   = in_ready_q;
  assign bus.start_o      = start_q;
  assign bus.gray_o       = gray;
  assign bus.busy_o       = busy_q;
  assign bus.frame_done_o = frame_done_q;

endmodule

// File: tb/tb_sobel_window_scheduler.sv
// Directed bench: W=5,H=4 scheduler for plain, backpressured and reset-interrupted frames,
// plus a W=3,H=3 instance for the single-window case. Input pixel = row*16+col.
module tb_sobel_window_scheduler;

  localparam int unsigned W  = 5;
  localparam int unsigned H  = 4;
  localparam int unsigned PW = 8;
  localparam int unsigned NS = 10 + 4 * (W - 3);

  logic clk_i = 1'b0;
  logic reset_i;

  int total = 0;
  int bad   = 0;
  int xfers = 0;

  always #5 clk_i = ~clk_i;

  sobel_window_scheduler_if #(.PIXEL_WIDTH(PW)) bus ();
  sobel_window_scheduler_if #(.PIXEL_WIDTH(PW)) bus3 ();

  sobel_window_scheduler #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .PIXEL_WIDTH (PW)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  sobel_window_scheduler #(
    .IMG_WIDTH   (3),
    .IMG_HEIGHT  (3),
    .PIXEL_WIDTH (PW)
  ) dut3 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus3)
  );

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(r * 16 + c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, counting accepted pixels of the main instance.
  task automatic step();
    if (bus.px_valid_i && bus.in_ready_o) xfers++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_frame();
    bus.frame_start_i = 1'b1;
    step();
    bus.frame_start_i = 1'b0;
  endtask

  // Send one raster row; alt inserts an invalid cycle before each pixel, hold keeps valid high after.
  task automatic send_row(input int r, input bit alt, input bit hold);
    for (int c = 0; c < int'(W); c++) begin
      if (alt) begin
        bus.px_valid_i = 1'b0;
        step();
      end
      bus.px_valid_i = 1'b1;
      bus.px_gray_i  = pix(r, c);
      step();
    end
    if (!hold) bus.px_valid_i = 1'b0;
  endtask

  // Check one strip starting at the LEAD cycle; top is the raster row of the oldest ring row.
  task automatic emit_check(input int top, input bit last);
    logic [7:0] e;
    int k;
    int j;
    int p;
    for (int i = 0; i < int'(NS); i++) begin
      if (i == 0) begin
        e = 8'h00;
      end else if (i < 10) begin
        k = i - 1;
        e = pix(top + k % 3, k / 3);
      end else begin
        j = i - 10;
        p = j % 4;
        e = (p == 0) ? 8'h00 : pix(top + p - 1, 3 + j / 4);
      end
      chk($sformatf("emit_t%0d_%0d", top, i), {bus.start_o, bus.gray_o}, {1'b1, e});
      step();
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("strip_end_t%0d_%0d", top, i),
          {bus.start_o, bus.gray_o, bus.in_ready_o}, 32'd0);
      step();
    end
    if (last) begin
      chk("done_pulse", {bus.frame_done_o, bus.busy_o, bus.in_ready_o}, 32'b100);
      step();
      chk("after_done", {bus.frame_done_o, bus.busy_o, bus.start_o}, 32'b000);
    end else begin
      chk($sformatf("refill_t%0d", top), {bus.in_ready_o, bus.busy_o, bus.start_o}, 32'b110);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i            = 1'b1;
    bus.frame_start_i  = 1'b0;
    bus.px_valid_i     = 1'b0;
    bus.px_gray_i      = '0;
    bus3.frame_start_i = 1'b0;
    bus3.px_valid_i    = 1'b0;
    bus3.px_gray_i     = '0;
    step();
    step();

    chk("rst_start", bus.start_o, 0);
    chk("rst_gray", bus.gray_o, 0);
    chk("rst_in_ready", bus.in_ready_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.frame_done_o, 0);
    reset_i = 1'b0;
    step();
    chk("idle_no_ready", bus.in_ready_o, 0);

    // Plain frame, with a frame_start pulse while busy.
    xfers = 0;
    start_frame();
    chk("fill_a", {bus.busy_o, bus.in_ready_o}, 32'b11);
    send_row(0, 1'b0, 1'b0);
    send_row(1, 1'b0, 1'b0);
    send_row(2, 1'b0, 1'b0);
    emit_check(0, 1'b0);
    bus.frame_start_i = 1'b1;
    step();
    bus.frame_start_i = 1'b0;
    chk("fs_ignored", {bus.busy_o, bus.in_ready_o, bus.start_o}, 32'b110);
    send_row(3, 1'b0, 1'b0);
    emit_check(1, 1'b1);
    chk("xfers_a", xfers, 32'd20);

    // Backpressured fill, valid held high during emission.
    xfers = 0;
    start_frame();
    send_row(0, 1'b1, 1'b1);
    send_row(1, 1'b1, 1'b1);
    send_row(2, 1'b1, 1'b1);
    emit_check(0, 1'b0);
    send_row(3, 1'b1, 1'b1);
    emit_check(1, 1'b1);
    bus.px_valid_i = 1'b0;
    chk("xfers_b", xfers, 32'd20);

    // Reset in the 6th first-window cycle, then a fresh frame.
    start_frame();
    send_row(0, 1'b0, 1'b0);
    send_row(1, 1'b0, 1'b0);
    send_row(2, 1'b0, 1'b0);
    chk("lead_c", {bus.start_o, bus.gray_o}, {1'b1, 8'h00});
    for (int i = 0; i < 6; i++) step();
    chk("pix1st_6", {bus.start_o, bus.gray_o}, {1'b1, pix(2, 1)});
    #1;
    reset_i = 1'b1;
    #1;
    chk("rst_mid", {bus.start_o, bus.gray_o, bus.in_ready_o, bus.busy_o, bus.frame_done_o},
        32'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    step();
    chk("post_rst_idle", {bus.busy_o, bus.in_ready_o, bus.start_o}, 32'b000);
    xfers = 0;
    start_frame();
    send_row(0, 1'b0, 1'b0);
    send_row(1, 1'b0, 1'b0);
    send_row(2, 1'b0, 1'b0);
    emit_check(0, 1'b0);
    send_row(3, 1'b0, 1'b0);
    emit_check(1, 1'b1);
    chk("xfers_c", xfers, 32'd20);

    // W=3,H=3: a single window, no gap cycles.
    bus3.frame_start_i = 1'b1;
    step();
    bus3.frame_start_i = 1'b0;
    chk("w3_fill", {bus3.busy_o, bus3.in_ready_o}, 32'b11);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        bus3.px_valid_i = 1'b1;
        bus3.px_gray_i  = pix(r, c);
        step();
      end
    end
    bus3.px_valid_i = 1'b0;
    chk("w3_lead", {bus3.start_o, bus3.gray_o, bus3.in_ready_o}, {1'b1, 8'h00, 1'b0});
    step();
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("w3_pix%0d", k), {bus3.start_o, bus3.gray_o}, {1'b1, pix(k % 3, k / 3)});
      step();
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("w3_end%0d", i), {bus3.start_o, bus3.gray_o, bus3.frame_done_o}, 32'd0);
      step();
    end
    chk("w3_done", {bus3.frame_done_o, bus3.busy_o}, 32'b10);
    step();
    chk("w3_idle", {bus3.frame_done_o, bus3.busy_o, bus3.in_ready_o}, 32'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
